// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and the saturating gain helper for the audio
//               sample path. sample_t/stereo_t describe the default 24-bit
//               configuration; sat_gain is width-generic and is called with
//               the instantiating module's parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int C_DATA_W = 24;

    typedef logic signed [C_DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    // Scale a sign-extended sample by an unsigned volume code, where code
    // 2^(vol_w-1) is unity, then clamp to the signed range of data_w bits.
    // Carried at 64 bits so the product can never wrap; the caller keeps
    // the low data_w bits, which hold the clamped value exactly.
    function automatic logic signed [63:0] sat_gain(
        input logic signed [63:0] sample,
        input logic [15:0]        volume,
        input int                 data_w,
        input int                 vol_w
    );
        logic signed [63:0] prod;
        logic signed [63:0] scaled;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        prod   = sample * $signed({48'd0, volume});
        scaled = prod >>> (vol_w - 1);
        max_v  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v  = -(64'sd1 <<< (data_w - 1));
        if (scaled > max_v) begin
            return max_v;
        end else if (scaled < min_v) begin
            return min_v;
        end
        return scaled;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stereo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stereo_fifo
// Description : Circular-buffer FIFO, DEPTH entries of WIDTH bits, with a
//               first-word-fall-through read port (dout shows the head entry
//               combinationally) and an occupancy count.
// Ports       : clk, rst (sync, active-high), push/din write side,
//               pop/dout read side, full, empty, level (0..DEPTH).
// Revision    : 1.0 - initial release
// ============================================================================
module stereo_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_lvl_w  = c_addr_w + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0]  r_level;

    // Storage carries no reset; validity is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_level == c_lvl_w'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/audio_gain_stream.sv
`default_nettype none
// ============================================================================
// Module      : audio_gain_stream
// Description : Codec ADC-to-DAC sample path. Pops stereo pairs from the
//               codec read side into a FIFO, applies a saturating signed
//               volume gain (or mute) as each pair moves into the output
//               register, and pushes the result to the codec write side.
// Ports       : CLOCK_50, reset (sync, active-high)
//               read_ready, readdata_left/right, read  - ADC side
//               write_ready, writedata_left/right, write - DAC side
//               volume, mute - gain control, sampled when a pair loads
//               level - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module audio_gain_stream
    import audio_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    parameter int VOL_W  = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     read_ready,
    input  logic [DATA_W-1:0]        readdata_left,
    input  logic [DATA_W-1:0]        readdata_right,
    output logic                     read,
    input  logic                     write_ready,
    output logic [DATA_W-1:0]        writedata_left,
    output logic [DATA_W-1:0]        writedata_right,
    output logic                     write,
    input  logic [VOL_W-1:0]         volume,
    input  logic                     mute,
    output logic [$clog2(DEPTH):0]   level
);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_read;
    logic                  w_write;
    logic                  w_load;
    logic [2*DATA_W-1:0]   w_fifo_dout;
    logic [DATA_W-1:0]     w_gain_left;
    logic [DATA_W-1:0]     w_gain_right;

    logic [DATA_W-1:0]     r_out_left;
    logic [DATA_W-1:0]     r_out_right;
    logic                  r_out_valid;

    // Both handshakes are suppressed during reset so no pair is consumed
    // from or delivered to the codec while state is being discarded.
    assign w_read  = read_ready & ~w_full & ~reset;
    assign w_write = r_out_valid & write_ready & ~reset;

    // The output register accepts a new pair when empty or when its current
    // pair leaves this cycle, which keeps one pair per cycle sustained.
    assign w_load  = ~w_empty & (~r_out_valid | w_write);

    stereo_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (w_read),
        .pop   (w_load),
        .din   ({readdata_left, readdata_right}),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign w_gain_left  = DATA_W'(sat_gain(64'($signed(w_fifo_dout[2*DATA_W-1:DATA_W])),
                                           16'(volume), DATA_W, VOL_W));
    assign w_gain_right = DATA_W'(sat_gain(64'($signed(w_fifo_dout[DATA_W-1:0])),
                                           16'(volume), DATA_W, VOL_W));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_left  <= '0;
            r_out_right <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_left  <= mute ? '0 : w_gain_left;
            r_out_right <= mute ? '0 : w_gain_right;
        end else if (w_write) begin
            r_out_valid <= 1'b0;
        end
    end

    assign read            = w_read;
    assign write           = w_write;
    assign writedata_left  = r_out_left;
    assign writedata_right = r_out_right;

endmodule
`default_nettype wire

// File: tb/tb_audio_gain_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_gain_stream
// Description : Self-checking bench for audio_gain_stream. A queue-based
//               reference model (FIFO of captured pairs plus one output slot,
//               gain computed with integer arithmetic) predicts read, write,
//               level and the DAC samples every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_gain_stream;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int VOL_W  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic                CLOCK_50 = 1'b0;
    logic                reset;
    logic                read_ready;
    logic [DATA_W-1:0]   readdata_left;
    logic [DATA_W-1:0]   readdata_right;
    logic                read;
    logic                write_ready;
    logic [DATA_W-1:0]   writedata_left;
    logic [DATA_W-1:0]   writedata_right;
    logic                write;
    logic [VOL_W-1:0]    volume;
    logic                mute;
    logic [LVL_W-1:0]    level;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_gain_stream #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .VOL_W  (VOL_W)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write           (write),
        .volume          (volume),
        .mute            (mute),
        .level           (level)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    int n_writes = 0;

    // Reference model state
    logic [2*DATA_W-1:0] m_fifo [$];
    bit                  m_valid = 1'b0;
    logic [DATA_W-1:0]   m_out_l = '0;
    logic [DATA_W-1:0]   m_out_r = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Gain from first principles: value * volume / 2^(VOL_W-1), rounded
    // toward minus infinity, clamped to the signed DATA_W range.
    function automatic logic [DATA_W-1:0] ref_gain(input logic [DATA_W-1:0] s,
                                                   input int vol, input bit mt);
        longint sv, p, r, hi, lo;
        logic [63:0] bits;
        if (mt) return '0;
        sv = longint'($signed(s));
        p  = sv * vol;
        r  = p >>> (VOL_W - 1);
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        bits = r;
        return bits[DATA_W-1:0];
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // 1 time unit later, then advance the model across the rising edge.
    task automatic step(input bit rst, input bit rr, input logic [DATA_W-1:0] l,
                        input logic [DATA_W-1:0] r, input bit wr,
                        input logic [VOL_W-1:0] vol, input bit mt);
        bit exp_read, exp_write;
        logic [2*DATA_W-1:0] pair;
        reset          = rst;
        read_ready     = rr;
        readdata_left  = l;
        readdata_right = r;
        write_ready    = wr;
        volume         = vol;
        mute           = mt;
        #1;
        exp_read  = !rst && rr && (m_fifo.size() < DEPTH);
        exp_write = !rst && m_valid && wr;
        check_eq("read", read, exp_read);
        check_eq("write", write, exp_write);
        check_eq("level", level, m_fifo.size());
        check_eq("wd_left", writedata_left, m_out_l);
        check_eq("wd_right", writedata_right, m_out_r);
        if (read)  n_reads++;
        if (write) n_writes++;
        @(posedge CLOCK_50);
        if (rst) begin
            m_fifo.delete();
            m_valid = 1'b0;
            m_out_l = '0;
            m_out_r = '0;
        end else begin
            if (exp_write) m_valid = 1'b0;
            if (!m_valid && m_fifo.size() > 0) begin
                pair    = m_fifo.pop_front();
                m_out_l = ref_gain(pair[2*DATA_W-1:DATA_W], int'(vol), mt);
                m_out_r = ref_gain(pair[DATA_W-1:0], int'(vol), mt);
                m_valid = 1'b1;
            end
            if (exp_read) m_fifo.push_back({l, r});
        end
        @(negedge CLOCK_50);
    endtask

    task automatic idle(input int n, input bit wr, input logic [VOL_W-1:0] vol, input bit mt);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, wr, vol, mt);
    endtask

    initial begin
        // Power-up: outputs are unknown before the first reset edge.
        reset = 1'b1; read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = '0; readdata_right = '0; volume = 4'd8; mute = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        step(1'b1, 1'b1, 24'h111111, 24'h222222, 1'b1, 4'd8, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 4'd8, 1'b0);

        // Unity pass-through with minimum latency.
        step(1'b0, 1'b1, 24'h000100, 24'hFFFF00, 1'b1, 4'd8, 1'b0);
        idle(3, 1'b1, 4'd8, 1'b0);

        // Gain and saturation at volume 15.
        step(1'b0, 1'b1, 24'h100000, 24'hA00000, 1'b1, 4'd15, 1'b0);
        step(1'b0, 1'b1, 24'h600000, 24'h000001, 1'b1, 4'd15, 1'b0);
        step(1'b0, 1'b1, 24'h7FFFFF, 24'h800000, 1'b1, 4'd15, 1'b0);
        idle(3, 1'b1, 4'd15, 1'b0);

        // Mute still produces write strobes.
        step(1'b0, 1'b1, 24'h123456, 24'h123456, 1'b1, 4'd8, 1'b1);
        idle(3, 1'b1, 4'd8, 1'b1);

        // Backpressure: DEPTH in the FIFO plus one in the output register.
        n_reads = 0;
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0, 4'd8, 1'b0);
        check_eq("bp_reads", n_reads, DEPTH + 1);
        check_eq("bp_level", level, DEPTH);
        n_writes = 0;
        idle(12, 1'b1, 4'd8, 1'b0);
        check_eq("bp_writes", n_writes, DEPTH + 1);

        // Random stream with toggling backpressure and changing gain.
        n_writes = 0;
        for (int cyc = 0; cyc < 4000 && n_writes < 100; cyc++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), DATA_W'($urandom), DATA_W'($urandom),
                 $urandom_range(0, 1) == 1, VOL_W'($urandom), ($urandom_range(0, 15) == 0));
            check_eq("level_bound", (level <= DEPTH), 1'b1);
        end
        check_eq("stream_count", (n_writes >= 100), 1'b1);
        idle(DEPTH + 3, 1'b1, 4'd8, 1'b0);

        // Reset with pairs buffered, then confirm a clean restart.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0, 4'd12, 1'b0);
        check_eq("pre_rst_level", level, 4);
        step(1'b1, 1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b1, 4'd12, 1'b0);
        step(1'b0, 1'b1, 24'h0ABCDE, 24'hFEDCBA, 1'b1, 4'd12, 1'b0);
        idle(3, 1'b1, 4'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_gain_stream.md
# audio_gain_stream

Parametrised audio sample path between the codec's read and write interfaces. Captures stereo sample pairs whenever the codec has ADC data, buffers them in a small FIFO, applies a signed volume gain with saturation or mute, and writes the result back to the DAC. Sits in the top level in place of fixed `read`/`write` tie-offs, driving the `audio_codec` handshake directly.

## Interface
- `DATA_W`, 24: sample width per channel, two's complement.
- `DEPTH`, 8: FIFO depth in sample pairs; power of two, ≥ 2.
- `VOL_W`, 4: volume code width. Unity gain is code `2^(VOL_W-1)`.
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `read_ready` in 1: codec has an ADC sample pair available.
- `readdata_left` in DATA_W: ADC left sample.
- `readdata_right` in DATA_W: ADC right sample.
- `read` out 1: pops one pair from the codec this cycle.
- `write_ready` in 1: codec can accept a DAC sample pair.
- `writedata_left` out DATA_W: DAC left sample.
- `writedata_right` out DATA_W: DAC right sample.
- `write` out 1: pushes one pair to the codec this cycle.
- `volume` in VOL_W: unsigned gain code.
- `mute` in 1: forces output samples to 0.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Capture:
  - `read = read_ready & ~fifo_full & ~reset`, combinational.
  - When `read` is high, `{readdata_left, readdata_right}` is pushed into the FIFO at the clock edge.
  - No pair is read while the FIFO is full; the codec holds its data.
- FIFO:
  - Circular buffer, DEPTH entries × 2·DATA_W bits.
  - Read/write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave `level` unchanged.
  - Pop on empty never occurs.
- Gain stage: one output register pair plus an `out_valid` flag.
  - Loads when the FIFO is non-empty and the register is free (`~out_valid`, or `write` this cycle). The load pops the FIFO.
  - Per channel: `p = s * $signed({1'b0, volume})`, width DATA_W+VOL_W+1.
  - Then `r = p >>> (VOL_W-1)`.
  - Saturate `r` to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - `mute=1` yields 0 on both channels.
  - `volume` and `mute` are sampled at load time; later changes do not affect a loaded pair.
- Output:
  - `write = out_valid & write_ready`.
  - `writedata_*` drive the gain registers directly.
  - `out_valid` clears on `write` unless a new pair loads in the same cycle.
- Reset:
  - Pointers, `level`, and `out_valid` go to 0; gain registers go to 0.
  - `read` and `write` are 0 during any reset cycle.
  - A reset mid-stream discards all buffered and in-flight pairs.

## Timing
- Reset values: `read`=0, `write`=0, `writedata_left`=0, `writedata_right`=0, `level`=0.
- Minimum latency from a `read` cycle N to a `write` cycle is N+2, with `write_ready` held high:
  - edge N: FIFO push;
  - edge N+1: gain load;
  - cycle N+2: `write`.
- Sustained throughput: one pair per cycle when `read_ready` and `write_ready` are both continuously high.
- `level` updates one cycle after the push/pop.
- Full condition: `level == DEPTH`; empty: `level == 0`.
- Backpressure: with `write_ready` low, the FIFO fills to DEPTH, then the register holds one more pair, so DEPTH+1 pairs are in flight. `read` then drops to 0.

## Structure
- Package `audio_pkg`:
  - `sample_t` (logic signed [DATA_W-1:0]);
  - `stereo_t` struct {left, right};
  - function `sat_gain(sample, volume)` returning the saturated scaled sample.
- Sub-module `stereo_fifo`: parametrised DEPTH/width. Ports: push, pop, din, dout, full, empty, level.
- Top `audio_gain_stream`: handshake logic, two `sat_gain` calls, output register.

## Test plan
- Unity pass-through: volume=8, mute=0, push L=0x000100, R=0xFFFF00 with both readies high → `write` at cycle N+2 with L=0x000100, R=0xFFFF00.
- Gain and saturation, volume=15:
  - L=0x100000 → 0x1E0000;
  - L=0x600000 → 0x7FFFFF;
  - R=0xA00000 → 0x800000.
- Mute: mute=1, volume=8, input 0x123456 → output 0x000000; `write` is still asserted.
- Backpressure:
  - With `write_ready`=0, drive 12 reads. `read` is high for exactly 9 pairs (DEPTH+1) and `level` reads 8.
  - Release `write_ready`: 9 writes come out in input order, with no loss or duplication.
- Wrap-around: stream 100 pairs with a randomly toggling `write_ready` → output sequence equals the input sequence scaled by gain; `level` never exceeds 8.
- Reset mid-stream: assert `reset` with 5 pairs buffered → next cycle `level`=0, `write`=0, `writedata_*`=0; the first post-reset write is the first post-reset read.
